// File: rtl/ac_pkg.sv
// Shared state codes and default thresholds for the air-conditioning sequencer.
package ac_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEAT    = 2'd1,
        COOL    = 2'd2,
        LOCKOUT = 2'd3
    } ac_state_e;

    localparam int unsigned AC_DEF_LOW  = 18;
    localparam int unsigned AC_DEF_HIGH = 22;
    // Smallest accepted distance between heat-on and cool-on thresholds.
    localparam int unsigned AC_MIN_GAP  = 2;

endpackage

// File: rtl/ac_sequencer_if.sv
// Band-reconfiguration handshake between a requester (master) and the sequencer (slave).
interface ac_sequencer_if #(
    parameter int unsigned TEMP_W = 5
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [TEMP_W-1:0] cfg_low;
    logic [TEMP_W-1:0] cfg_high;
    logic              cfg_err;

    modport master (output cfg_valid, cfg_low, cfg_high, input cfg_ready, cfg_err);
    modport slave  (input cfg_valid, cfg_low, cfg_high, output cfg_ready, cfg_err);
endinterface

// File: rtl/ac_hold_timer.sv
// Saturating up-counter with synchronous clear; done is high once N counts have elapsed.
module ac_hold_timer #(
    parameter int unsigned N = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);
    localparam int unsigned    CW    = $clog2(N + 2);
    localparam logic [CW-1:0]  LIMIT = CW'(N);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign done = (cnt == LIMIT);
endmodule

// File: rtl/ac_sequencer.sv
// Heating/cooling supervisor: hysteresis band, minimum run, post-run lockout and fan drive.
// Define AC_SEQ_FAN_OVERRUN_EN to keep the fan running FAN_OVR cycles after each run.
module ac_sequencer
    import ac_pkg::*;
#(
    parameter int unsigned TEMP_W   = 5,
    parameter int unsigned DEF_LOW  = AC_DEF_LOW,
    parameter int unsigned DEF_HIGH = AC_DEF_HIGH,
    parameter int unsigned MIN_ON   = 4,
    parameter int unsigned MIN_OFF  = 4,
    parameter int unsigned FAN_OVR  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TEMP_W-1:0] temperature,
    ac_sequencer_if.slave     cfg,
    output logic              heating,
    output logic              cooling,
    output logic              fan,
    output logic [1:0]        state
);
    localparam logic [TEMP_W-1:0] DEF_MID = TEMP_W'((DEF_LOW + DEF_HIGH) >> 1);

    if (MIN_ON < 1 || MIN_OFF < 1 || FAN_OVR < 1) begin : g_bad_param
        $error("ac_sequencer: MIN_ON, MIN_OFF and FAN_OVR must be at least 1");
    end

    ac_state_e         state_q, state_d;
    logic [TEMP_W-1:0] low_q, high_q, mid_q;
    logic [TEMP_W-1:0] mid_new;
    logic [TEMP_W:0]   band_sum;
    logic              ready_q, err_q;
    logic              xfer, band_ok;
    logic              running, running_d;
    logic              run_done, lock_done;

    assign running   = (state_q == HEAT) || (state_q == COOL);
    assign running_d = (state_d == HEAT) || (state_d == COOL);

    ac_hold_timer #(.N(MIN_ON - 1)) u_run_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (!running),
        .en   (running),
        .done (run_done)
    );

    ac_hold_timer #(.N(MIN_OFF - 1)) u_lock_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q != LOCKOUT),
        .en   (state_q == LOCKOUT),
        .done (lock_done)
    );

    assign xfer     = cfg.cfg_valid && ready_q;
    assign band_ok  = {1'b0, cfg.cfg_high} >= ({1'b0, cfg.cfg_low} + (TEMP_W+1)'(AC_MIN_GAP));
    assign band_sum = {1'b0, cfg.cfg_low} + {1'b0, cfg.cfg_high};
    assign mid_new  = TEMP_W'(band_sum >> 1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (temperature <= low_q)       state_d = HEAT;
                else if (temperature >= high_q) state_d = COOL;
            end
            HEAT: begin
                if (temperature >= high_q)                     state_d = LOCKOUT;
                else if ((temperature >= mid_q) && run_done)   state_d = LOCKOUT;
            end
            COOL: begin
                if (temperature <= low_q)                      state_d = LOCKOUT;
                else if ((temperature <= mid_q) && run_done)   state_d = LOCKOUT;
            end
            LOCKOUT: begin
                if (lock_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            heating <= 1'b0;
            cooling <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            low_q   <= TEMP_W'(DEF_LOW);
            high_q  <= TEMP_W'(DEF_HIGH);
            mid_q   <= DEF_MID;
        end else begin
            state_q <= state_d;
            heating <= (state_d == HEAT);
            cooling <= (state_d == COOL);
            ready_q <= (state_d == IDLE);
            err_q   <= xfer && !band_ok;
            if (xfer && band_ok) begin
                low_q  <= cfg.cfg_low;
                high_q <= cfg.cfg_high;
                mid_q  <= mid_new;
            end
        end
    end

`ifdef AC_SEQ_FAN_OVERRUN_EN
    logic ovr_done;

    // Counts only while the fan is coasting; any run restarts the overrun window.
    ac_hold_timer #(.N(FAN_OVR - 1)) u_fan_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (running),
        .en   (fan && !running),
        .done (ovr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fan <= 1'b0;
        else     fan <= running_d || (fan && (running || !ovr_done));
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fan <= 1'b0;
        else     fan <= running_d;
    end
`endif

    assign state         = state_q;
    assign cfg.cfg_ready = ready_q;
    assign cfg.cfg_err   = err_q;

endmodule

// File: tb/tb_ac_sequencer.sv
// Directed vector bench for ac_sequencer (default band 18/22, MIN_ON=MIN_OFF=4, FAN_OVR=3).
module tb_ac_sequencer;

    typedef struct {
        logic       rst;
        logic [4:0] t;
        logic       v;
        logic [4:0] lo;
        logic [4:0] hi;
        logic       h;
        logic       c;
        logic       fo;
        logic [1:0] st;
        logic       rdy;
        logic       err;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [4:0] temperature;
    logic       heating, cooling, fan;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t tbl[$];

    ac_sequencer_if #(.TEMP_W(5)) cfg_if ();

    ac_sequencer #(
        .TEMP_W   (5),
        .DEF_LOW  (18),
        .DEF_HIGH (22),
        .MIN_ON   (4),
        .MIN_OFF  (4),
        .FAN_OVR  (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .temperature (temperature),
        .cfg         (cfg_if),
        .heating     (heating),
        .cooling     (cooling),
        .fan         (fan),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic row(input int r, input int t, input int v, input int lo, input int hi,
                       input int h, input int c, input int fo, input int st,
                       input int rdy, input int err);
        vec_t x;
        x.rst = r[0];   x.t  = t[4:0];  x.v  = v[0];
        x.lo  = lo[4:0]; x.hi = hi[4:0];
        x.h   = h[0];   x.c  = c[0];    x.fo = fo[0];
        x.st  = st[1:0]; x.rdy = rdy[0]; x.err = err[0];
        tbl.push_back(x);
    endtask

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d, expected %0d", nm, idx, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        temperature = 5'd16;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_low   = '0;
        cfg_if.cfg_high  = '0;

        //   rst  t  v lo hi   h c fo st rdy err
        // reset, release into HEAT, minimum run, lockout
        row(1, 16, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        row(0, 16, 0, 0, 0,   1, 0, 1, 1, 0, 0);
        row(0, 20, 0, 0, 0,   1, 0, 1, 1, 0, 0);
        row(0, 20, 0, 0, 0,   1, 0, 1, 1, 0, 0);
        row(0, 20, 0, 0, 0,   1, 0, 1, 1, 0, 0);
        row(0, 20, 0, 0, 0,   0, 0, 1, 3, 0, 0);
        row(0, 20, 0, 0, 0,   0, 0, 1, 3, 0, 0);
        row(0, 20, 0, 0, 0,   0, 0, 1, 3, 0, 0);
        row(0, 20, 0, 0, 0,   0, 0, 0, 3, 0, 0);
        row(0, 20, 0, 0, 0,   0, 0, 0, 0, 1, 0);
        // safety exit from HEAT, lockout ignores temperature, then COOL run
        row(0, 17, 0, 0, 0,   1, 0, 1, 1, 0, 0);
        row(0, 23, 0, 0, 0,   0, 0, 1, 3, 0, 0);
        row(0, 23, 0, 0, 0,   0, 0, 1, 3, 0, 0);
        row(0, 23, 0, 0, 0,   0, 0, 1, 3, 0, 0);
        row(0, 23, 0, 0, 0,   0, 0, 0, 3, 0, 0);
        row(0, 23, 0, 0, 0,   0, 0, 0, 0, 1, 0);
        row(0, 23, 0, 0, 0,   0, 1, 1, 2, 0, 0);
        row(0, 21, 0, 0, 0,   0, 1, 1, 2, 0, 0);
        row(0, 21, 0, 0, 0,   0, 1, 1, 2, 0, 0);
        row(0, 21, 0, 0, 0,   0, 1, 1, 2, 0, 0);
        row(0, 20, 0, 0, 0,   0, 0, 1, 3, 0, 0);
        row(0, 20, 0, 0, 0,   0, 0, 1, 3, 0, 0);
        row(0, 20, 0, 0, 0,   0, 0, 1, 3, 0, 0);
        row(0, 20, 0, 0, 0,   0, 0, 0, 3, 0, 0);
        row(0, 20, 0, 0, 0,   0, 0, 0, 0, 1, 0);
        // rejected band 15/16; 18/22 stays in force (19 idle, 18 heats, 19 never exits)
        row(0, 20, 1, 15, 16, 0, 0, 0, 0, 1, 1);
        row(0, 20, 0, 0, 0,   0, 0, 0, 0, 1, 0);
        row(0, 19, 0, 0, 0,   0, 0, 0, 0, 1, 0);
        row(0, 18, 0, 0, 0,   1, 0, 1, 1, 0, 0);
        // band 10/14 offered during HEAT and lockout: held off until IDLE
        row(0, 19, 1, 10, 14, 1, 0, 1, 1, 0, 0);
        row(0, 19, 1, 10, 14, 1, 0, 1, 1, 0, 0);
        row(0, 19, 1, 10, 14, 1, 0, 1, 1, 0, 0);
        row(0, 19, 1, 10, 14, 1, 0, 1, 1, 0, 0);
        row(0, 20, 1, 10, 14, 0, 0, 1, 3, 0, 0);
        row(0, 20, 1, 10, 14, 0, 0, 1, 3, 0, 0);
        row(0, 20, 1, 10, 14, 0, 0, 1, 3, 0, 0);
        row(0, 20, 1, 10, 14, 0, 0, 0, 3, 0, 0);
        row(0, 20, 1, 10, 14, 0, 0, 0, 0, 1, 0);
        // accepted here; decision on this edge still uses the old band
        row(0, 20, 1, 10, 14, 0, 0, 0, 0, 1, 0);
        row(0, 12, 0, 0, 0,   0, 0, 0, 0, 1, 0);
        row(0, 10, 0, 0, 0,   1, 0, 1, 1, 0, 0);
        row(0, 12, 0, 0, 0,   1, 0, 1, 1, 0, 0);
        row(0, 12, 0, 0, 0,   1, 0, 1, 1, 0, 0);
        row(0, 12, 0, 0, 0,   1, 0, 1, 1, 0, 0);
        row(0, 12, 0, 0, 0,   0, 0, 1, 3, 0, 0);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            logic exp_fan;
            rst              = tbl[i].rst;
            temperature      = tbl[i].t;
            cfg_if.cfg_valid = tbl[i].v;
            cfg_if.cfg_low   = tbl[i].lo;
            cfg_if.cfg_high  = tbl[i].hi;
`ifdef AC_SEQ_FAN_OVERRUN_EN
            exp_fan = tbl[i].fo;
`else
            exp_fan = tbl[i].h | tbl[i].c;
`endif
            @(posedge clk);
            #1;
            chk("heating",   i, 8'(heating),          8'(tbl[i].h));
            chk("cooling",   i, 8'(cooling),          8'(tbl[i].c));
            chk("fan",       i, 8'(fan),              8'(exp_fan));
            chk("state",     i, 8'(state),            8'(tbl[i].st));
            chk("cfg_ready", i, 8'(cfg_if.cfg_ready), 8'(tbl[i].rdy));
            chk("cfg_err",   i, 8'(cfg_if.cfg_err),   8'(tbl[i].err));
            @(negedge clk);
        end

        // finish the lockout, start heating on the 10/14 band, then reset mid-run
        cfg_if.cfg_valid = 1'b0;
        temperature = 5'd12;
        repeat (4) @(posedge clk);
        #1;
        chk("seq_idle_after_lock", 100, 8'(state), 8'd0);
        @(negedge clk);
        temperature = 5'd10;
        @(posedge clk);
        #1;
        chk("seq_heat_start", 101, 8'(heating), 8'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_heating", 102, 8'(heating), 8'd0);
        chk("async_rst_state",   103, 8'(state),   8'd0);
        chk("async_rst_fan",     104, 8'(fan),     8'd0);
        chk("async_rst_ready",   105, 8'(cfg_if.cfg_ready), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        temperature = 5'd20;
        @(posedge clk);
        #1;
        chk("post_rst_no_lockout", 106, 8'(state), 8'd0);
        chk("post_rst_ready",      107, 8'(cfg_if.cfg_ready), 8'd1);
        @(negedge clk);
        temperature = 5'd18;
        @(posedge clk);
        #1;
        chk("post_rst_default_low", 108, 8'(heating), 8'd1);
        chk("post_rst_state_heat",  109, 8'(state),   8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ac_sequencer.md
Name: ac_sequencer

Overview:
- Supervisory controller that owns the heating/cooling actuators of the air-conditioning datapath.
- Replaces the bare threshold comparator with a sequenced FSM: programmable hysteresis band, minimum run time, post-run compressor lockout and a fan output.
- Sits between the temperature sensor bus and the heater/cooler drivers.
- The band is reconfigured over a valid/ready handshake.

Parameters:
- TEMP_W, 5: temperature and threshold width (unsigned degrees).
- DEF_LOW, 18: reset value of the heat-on threshold.
- DEF_HIGH, 22: reset value of the cool-on threshold.
- MIN_ON, 4: minimum cycles heating/cooling stays asserted (>=1).
- MIN_OFF, 4: lockout cycles with both actuators off after any run (>=1).
- FAN_OVR, 3: fan overrun cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- temperature  in  TEMP_W  current temperature, sampled at posedge clk
- cfg_valid  in  1  new band offered
- cfg_ready  out  1  sequencer can accept a band (IDLE only)
- cfg_low  in  TEMP_W  proposed heat-on threshold
- cfg_high  in  TEMP_W  proposed cool-on threshold
- cfg_err  out  1  one-cycle pulse: offered band rejected
- heating  out  1  heater drive
- cooling  out  1  cooler drive
- fan  out  1  fan drive
- state  out  2  FSM state code for status/debug

Behaviour:
- Reset (async, immediate):
  - state=IDLE; heating=cooling=fan=cfg_err=cfg_ready=0.
  - low=DEF_LOW, high=DEF_HIGH; all counters 0.
- Outputs and thresholds:
  - All outputs are registered; heating=(state==HEAT), cooling=(state==COOL).
  - mid=(low+high)>>1, computed at TEMP_W+1 bits, truncated; recomputed when the band loads.
- State codes: IDLE=0, HEAT=1, COOL=2, LOCKOUT=3.
- IDLE:
  - temperature<=low -> HEAT. Heating is high from the same edge; run counter cleared.
  - temperature>=high -> COOL, likewise.
  - Otherwise stay.
  - low<high always holds, so both conditions can never be true together.
- HEAT:
  - Run counter increments each cycle.
  - Normal exit -> LOCKOUT when temperature>=mid AND run_cnt>=MIN_ON-1. Heating is therefore high for at least MIN_ON cycles.
  - Safety exit -> LOCKOUT immediately when temperature>=high, ignoring MIN_ON.
- COOL:
  - Mirror of HEAT: normal exit when temperature<=mid with MIN_ON satisfied.
  - Safety exit when temperature<=low.
- LOCKOUT:
  - heating=cooling=0 for exactly MIN_OFF cycles, then -> IDLE.
  - Temperature is ignored during lockout.
  - HEAT/COOL can never be entered directly from each other or from LOCKOUT.
- Config handshake:
  - cfg_ready=1 only in IDLE and not in reset.
  - Transfer occurs on a posedge with cfg_valid&&cfg_ready.
  - Band valid iff cfg_high>=cfg_low+2 (TEMP_W+1-bit compare). Valid: low/high load on that edge. Invalid: thresholds unchanged, cfg_err=1 for exactly one cycle.
  - Transfer and IDLE temperature evaluation on the same edge: the temperature decision uses the old thresholds; the new band applies from the next cycle.
  - cfg_valid while not in IDLE: no transfer. The requester holds cfg_valid and the offer is accepted in the first IDLE cycle.
- Saturation and extremes:
  - Counters saturate; they do not wrap.
  - temperature=0 or 2^TEMP_W-1 needs no special handling.
- Reset mid-run: actuators drop asynchronously; no lockout after reset release.

Optional Feature:
- Macro: AC_SEQ_FAN_OVERRUN_EN.
- Defined: fan=1 in HEAT/COOL and stays 1 for FAN_OVR cycles after leaving HEAT/COOL (into LOCKOUT). A re-entry during overrun keeps fan high continuously.
- Undefined: fan=heating|cooling; FAN_OVR is unused and no overrun counter is built.

Decomposition:
- Package ac_pkg:
  - State enum/localparams (IDLE/HEAT/COOL/LOCKOUT codes).
  - DEF_LOW/DEF_HIGH defaults.
  - Minimum band gap constant (2).
- Sub-module ac_hold_timer: saturating up-counter with clear and a ">=N" flag. Instanced for the run count, the lockout count and, under the macro, the fan overrun.

Test Plan:
- Reset:
  - rst=1 with temperature=16 -> heating=cooling=fan=0, cfg_ready=0.
  - Release -> heating=1 after the first edge, state=1.
- Minimum run:
  - Defaults; temperature 17 for 1 cycle, then 20 -> heating high exactly 4 cycles.
  - Then 4 cycles of both 0 (state=3), then state=0.
- Safety exit and lockout:
  - In HEAT, temperature jumps 17->23 -> heating=0 next edge.
  - cooling stays 0 through 4 lockout cycles, then rises on the edge after IDLE is re-entered.
- Valid config:
  - In IDLE, cfg_low=10, cfg_high=14, cfg_valid=1 -> accepted in one cycle.
  - temperature=12: no action. temperature=10: heating=1. Heating exits at 12 after MIN_ON.
- Invalid/blocked config:
  - cfg_low=15, cfg_high=16 -> cfg_err pulses 1 cycle; 18/22 band still in force.
  - cfg_valid raised during HEAT -> cfg_ready=0 until IDLE, then accepted.
- Fan overrun (macro defined, FAN_OVR=3):
  - Heating ends -> fan stays 1 for 3 more cycles, then 0.
  - Macro undefined -> fan tracks heating|cooling exactly.
